// File: rtl/game_soc_pio_ext.sv
// Avalon-MM parallel I/O port: per-bit direction, atomic set/clear of outputs,
// synchronised inputs with edge capture and a maskable interrupt.
module game_soc_pio_ext #(
  parameter int unsigned WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int unsigned EDGE_TYPE   = 0,
  parameter int unsigned IRQ_LEVEL   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  localparam logic [WIDTH-1:0] RST_DOUT    = RESET_VALUE[WIDTH-1:0];
  localparam logic [2:0]       ADDR_DATA   = 3'd0;
  localparam logic [2:0]       ADDR_DIR    = 3'd1;
  localparam logic [2:0]       ADDR_MASK   = 3'd2;
  localparam logic [2:0]       ADDR_CAP    = 3'd3;
  localparam logic [2:0]       ADDR_OUTSET = 3'd4;
  localparam logic [2:0]       ADDR_OUTCLR = 3'd5;
  localparam logic [1:0]       SETTLED     = 2'd3;

  logic [WIDTH-1:0] r_dout;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_cap;
  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_s3;
  logic [1:0]       r_settle;
  logic             r_irq;

  logic             w_we;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_det;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_rd;

  assign w_we  = chipselect & ~write_n;
  assign w_wd  = writedata[WIDTH-1:0];
  assign w_clr = (w_we && address == ADDR_CAP) ? w_wd : '0;

  if (WIDTH < 32) begin : g_wd_hi
    logic w_unused_wd;
    assign w_unused_wd = ^writedata[31:WIDTH];
  end

  // Edge selection; suppressed until the synchroniser has filled after reset
  always_comb begin
    w_edge = r_s2 ^ r_s3;
    if (EDGE_TYPE == 0) begin
      w_edge = r_s2 & ~r_s3;
    end else if (EDGE_TYPE == 1) begin
      w_edge = ~r_s2 & r_s3;
    end
    w_det = (r_settle == SETTLED) ? w_edge : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_s3     <= '0;
      r_settle <= '0;
    end else begin
      r_s1 <= in_port;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      if (r_settle != SETTLED) begin
        r_settle <= r_settle + 2'd1;
      end
    end
  end

  // Bus-visible registers; a fresh edge wins over a same-cycle clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dout <= RST_DOUT;
      r_dir  <= '0;
      r_mask <= '0;
      r_cap  <= '0;
    end else begin
      r_cap <= (r_cap & ~w_clr) | w_det;
      if (w_we) begin
        case (address)
          ADDR_DATA:   r_dout <= w_wd;
          ADDR_DIR:    r_dir  <= w_wd;
          ADDR_MASK:   r_mask <= w_wd;
          ADDR_OUTSET: r_dout <= r_dout | w_wd;
          ADDR_OUTCLR: r_dout <= r_dout & ~w_wd;
          default:     r_dout <= r_dout;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq <= 1'b0;
    end else if (IRQ_LEVEL != 0) begin
      r_irq <= |(r_s2 & r_mask);
    end else begin
      r_irq <= |(r_cap & r_mask);
    end
  end

  always_comb begin
    w_rd = '0;
    case (address)
      ADDR_DATA: w_rd = (r_dir & r_dout) | (~r_dir & r_s2);
      ADDR_DIR:  w_rd = r_dir;
      ADDR_MASK: w_rd = r_mask;
      ADDR_CAP:  w_rd = r_cap;
      default:   w_rd = '0;
    endcase
  end

  assign readdata = 32'(w_rd);
  assign out_port = r_dout;
  assign oe       = r_dir;
  assign irq      = r_irq;

endmodule
